// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester RAM port arbiter: lock states and requester ids.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one byte-enable RAM port between CPU (m0) and debug (m1) with lock support.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed m0 priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m0_req,
  input  logic                      m0_lock,
  input  logic [DATA_WIDTH/8-1:0]   m0_we,
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  output logic                      m0_gnt,
  output logic                      m0_rvalid,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_lock,
  input  logic [DATA_WIDTH/8-1:0]   m1_we,
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  output logic                      m1_gnt,
  output logic                      m1_rvalid,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic                      ram_en,
  output logic [DATA_WIDTH/8-1:0]   ram_we,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_di,
  input  logic [DATA_WIDTH-1:0]     ram_do
);

  localparam int NB = DATA_WIDTH / 8;

  lock_state_t state_q, state_d;
  logic        gnt0, gnt1;
  logic        rvalid0_q, rvalid1_q;
  req_id_t     favour;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t ptr_q;

  // Pointer hands contention to whoever was not served by the latest grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= REQ_CPU;
    else if (gnt0)
      ptr_q <= REQ_DBG;
    else if (gnt1)
      ptr_q <= REQ_CPU;
  end

  assign favour = ptr_q;
`else
  assign favour = REQ_CPU;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // A lock is taken only on a granted access and dropped by any cycle with lock low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt0 && m0_lock)
          state_d = LOCK0;
        else if (gnt1 && m1_lock)
          state_d = LOCK1;
      end
      LOCK0:   if (!m0_lock) state_d = IDLE;
      LOCK1:   if (!m1_lock) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants are gated by rst_n so the RAM port is quiet while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            gnt0 = (favour == REQ_CPU);
            gnt1 = (favour == REQ_DBG);
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        LOCK0:   gnt0 = m0_req;
        LOCK1:   gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 && (m0_we == '0);
      rvalid1_q <= gnt1 && (m1_we == '0);
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = ram_do;
  assign m1_rdata  = ram_do;

  assign ram_en   = gnt0 | gnt1;
  assign ram_we   = gnt0 ? m0_we : (gnt1 ? m1_we : {NB{1'b0}});
  assign ram_addr = gnt1 ? m1_addr : m0_addr;
  assign ram_di   = gnt1 ? m1_wdata : m0_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-enable RAM attached to its port.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [3:0]  m0_we, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_di, ram_do;

  logic [31:0] mem [0:1023];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  // Read-first RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_do <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
    end
  end

  task idle_all;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task issue_read(input logic id, input logic [9:0] addr);
    idle_all();
    if (id) begin m1_req = 1; m1_addr = addr; end
    else    begin m0_req = 1; m0_addr = addr; end
  endtask

  task test_reset;
    rst_n = 0;
    idle_all();
    m0_req = 1; m1_req = 1;
    @(negedge clk); #1;
    total++; if (m0_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rst_m0_gnt: got %b expected 0", m0_gnt); end
    total++; if (m1_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rst_m1_gnt: got %b expected 0", m1_gnt); end
    total++; if (ram_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_ram_en: got %b expected 0", ram_en); end
    total++; if (m0_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_m0_rvalid: got %b expected 0", m0_rvalid); end
    total++; if (m1_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_m1_rvalid: got %b expected 0", m1_rvalid); end
    @(negedge clk);
    idle_all();
    rst_n = 1;
  endtask

  task test_contention;
    logic e0;
    @(negedge clk);
    idle_all();
    m0_req = 1; m0_addr = 10'h020;
    m1_req = 1; m1_addr = 10'h030;
    for (int i = 0; i < 6; i++) begin
      #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      e0 = (i % 2 == 0);
`else
      e0 = 1'b1;
`endif
      total++;
      if (m0_gnt !== e0 || m1_gnt !== ~e0) begin
        bad++; $display("[TB] FAIL contention_gnt[%0d]: got %b%b expected %b%b", i, m0_gnt, m1_gnt, e0, ~e0);
      end
      total++;
      if (ram_addr !== (e0 ? 10'h020 : 10'h030)) begin
        bad++; $display("[TB] FAIL contention_addr[%0d]: got %h expected %h", i, ram_addr, e0 ? 10'h020 : 10'h030);
      end
      @(negedge clk);
    end
    idle_all();
  endtask

  task test_single_read;
    @(negedge clk);
    issue_read(1'b0, 10'h010);
    #1;
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL read_gnt: got %b expected 1", m0_gnt); end
    total++; if (ram_en !== 1'b1) begin bad++; $display("[TB] FAIL read_en: got %b expected 1", ram_en); end
    total++; if (ram_we !== 4'b0000) begin bad++; $display("[TB] FAIL read_we: got %b expected 0000", ram_we); end
    total++; if (ram_addr !== 10'h010) begin bad++; $display("[TB] FAIL read_addr: got %h expected 010", ram_addr); end
    @(negedge clk);
    total++; if (m0_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL read_rvalid: got %b expected 1", m0_rvalid); end
    total++; if (m0_rdata !== 32'hC0DE_0010) begin bad++; $display("[TB] FAIL read_data: got %h expected c0de0010", m0_rdata); end
    total++; if (m1_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL read_m1_rvalid: got %b expected 0", m1_rvalid); end
    idle_all();
  endtask

  task test_write_readback;
    @(negedge clk);
    idle_all();
    m1_req = 1; m1_we = 4'b0011; m1_addr = 10'h3FF; m1_wdata = 32'hA5A5_1234;
    #1;
    total++; if (m1_gnt !== 1'b1 || ram_we !== 4'b0011) begin bad++; $display("[TB] FAIL write_gnt: got %b/%b expected 1/0011", m1_gnt, ram_we); end
    @(negedge clk);
    total++; if (m1_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL write_no_rvalid: got %b expected 0", m1_rvalid); end
    issue_read(1'b0, 10'h3FF);
    @(negedge clk);
    total++; if (m0_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL readback_rvalid: got %b expected 1", m0_rvalid); end
    total++; if (m0_rdata !== 32'hC0DE_1234) begin bad++; $display("[TB] FAIL readback_data: got %h expected c0de1234", m0_rdata); end
    idle_all();
  endtask

  task test_lock;
    @(negedge clk);
    issue_read(1'b1, 10'h040);
    m1_lock = 1;
    #1;
    total++; if (m1_gnt !== 1'b1) begin bad++; $display("[TB] FAIL lock_take: got %b expected 1", m1_gnt); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m1_req = 0; m0_req = 1; m0_addr = 10'h050;
      #1;
      total++; if (m0_gnt !== 1'b0) begin bad++; $display("[TB] FAIL lock_stall[%0d]: got %b expected 0", i, m0_gnt); end
    end
    @(negedge clk);
    m1_lock = 0;
    #1;
    total++; if (m0_gnt !== 1'b0) begin bad++; $display("[TB] FAIL lock_release_cycle: got %b expected 0", m0_gnt); end
    @(negedge clk); #1;
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL lock_after: got %b expected 1", m0_gnt); end
    idle_all();
  endtask

  task test_reset_mid;
    @(negedge clk);
    issue_read(1'b0, 10'h005);
    m0_lock = 1;
    #1;
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL mid_gnt: got %b expected 1", m0_gnt); end
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    total++; if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin bad++; $display("[TB] FAIL mid_in_reset: got rvalid=%b gnt=%b expected 0/0", m0_rvalid, m0_gnt); end
    idle_all();
    @(negedge clk);
    rst_n = 1;
    #1;
    total++; if (m0_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rvalid_dropped: got %b expected 0", m0_rvalid); end
    m0_req = 1; m1_req = 1;
    #1;
    total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("[TB] FAIL mid_first_win: got %b%b expected 10", m0_gnt, m1_gnt); end
    @(negedge clk);
    m0_req = 0;
    #1;
    total++; if (m1_gnt !== 1'b1) begin bad++; $display("[TB] FAIL mid_unlocked: got %b expected 1", m1_gnt); end
    idle_all();
  endtask

  task test_back_to_back;
    logic       ids   [3] = '{1'b0, 1'b1, 1'b0};
    logic [9:0] addrs [3] = '{10'h001, 10'h002, 10'h003};
    logic       g;
    @(negedge clk);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) begin
        total++;
        if ((ids[k-1] ? m1_rvalid : m0_rvalid) !== 1'b1 || (ids[k-1] ? m0_rvalid : m1_rvalid) !== 1'b0) begin
          bad++; $display("[TB] FAIL b2b_rvalid[%0d]: got m0=%b m1=%b expected id %0d only", k-1, m0_rvalid, m1_rvalid, ids[k-1]);
        end
        total++;
        if ((ids[k-1] ? m1_rdata : m0_rdata) !== (32'hC0DE_0000 | {22'd0, addrs[k-1]})) begin
          bad++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", k-1, ids[k-1] ? m1_rdata : m0_rdata, 32'hC0DE_0000 | {22'd0, addrs[k-1]});
        end
      end
      if (k < 3) begin
        issue_read(ids[k], addrs[k]);
        #1;
        g = ids[k] ? m1_gnt : m0_gnt;
        total++; if (g !== 1'b1) begin bad++; $display("[TB] FAIL b2b_gnt[%0d]: got %b expected 1", k, g); end
        @(negedge clk);
      end
    end
    idle_all();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
    ram_do = '0;
    test_reset();
    test_contention();
    test_single_read();
    test_write_readback();
    test_lock();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
